// File: rtl/debug_monitor_pkg.sv
// Shared defaults for the probe viewer: word geometry, auto-scan dwell, board clock and slot map.
// Constants only; no logic, no latency, no flow control.
package debug_monitor_pkg;

    localparam int WORD_W_DEF    = 16;
    localparam int NUM_WORDS_DEF = 32;
    localparam int CLOCK_HZ      = 50_000_000;
    localparam int DWELL_DEF     = CLOCK_HZ;

    // Probe word slots as wired by fpga_top onto the flow core probe bus
    typedef enum logic [4:0] {
        SLOT_STATUS    = 5'd0,
        SLOT_RX_CNT    = 5'd1,
        SLOT_TX_CNT    = 5'd2,
        SLOT_DROP_CNT  = 5'd3,
        SLOT_CRED_LVL  = 5'd4,
        SLOT_FIFO_LVL  = 5'd5,
        SLOT_LAST_HDR  = 5'd6,
        SLOT_ERR_FLAGS = 5'd7
    } probe_slot_e;

endpackage

// File: rtl/debug_monitor_word_mux.sv
// Combinational NUM_WORDS:1 word selector over a flat bus; word i lives at [i*WORD_W +: WORD_W].
// Zero latency, no flow control.
module debug_monitor_word_mux #(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 32,
    parameter int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic [NUM_WORDS*WORD_W-1:0] bus,
    input  logic [IDX_W-1:0]            sel,
    output logic [WORD_W-1:0]           word
);

    assign word = bus[sel*WORD_W +: WORD_W];

endmodule

// File: rtl/debug_monitor.sv
// Probe viewer: manual/auto word select, freeze and value-trigger snapshot, byte-built switch word.
// view_word is one cycle behind index/probe; no backpressure, every input is acted on at once.
module debug_monitor
    import debug_monitor_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int DWELL     = DWELL_DEF,
    parameter int IDX_W     = $clog2(NUM_WORDS),
    parameter int LANE_W    = (WORD_W / 8 > 1) ? $clog2(WORD_W / 8) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_WORDS*WORD_W-1:0] probe,
    input  logic                        auto_mode,
    input  logic [IDX_W-1:0]            index_in,
    input  logic                        index_load,
    input  logic                        step,
    input  logic                        freeze,
    input  logic                        trig_en,
    input  logic [IDX_W-1:0]            trig_index,
    input  logic [WORD_W-1:0]           trig_value,
    input  logic [7:0]                  sw_byte,
    input  logic [LANE_W-1:0]           sw_lane,
    input  logic                        sw_load,
    output logic [WORD_W-1:0]           view_word,
    output logic [IDX_W-1:0]            view_index,
    output logic [WORD_W-1:0]           switch_word,
    output logic                        switch_nz,
    output logic                        frozen,
    output logic                        trig_hit
);

    localparam int NUM_LANES = WORD_W / 8;
    localparam int CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BUS_W     = NUM_WORDS * WORD_W;

    logic              step_prev_q, step_prev_d;
    logic              freeze_prev_q, freeze_prev_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic              frozen_q, frozen_d;
    logic              trig_hit_q, trig_hit_d;
    logic [BUS_W-1:0]  snap_q, snap_d;
    logic [WORD_W-1:0] switch_q, switch_d;
    logic [WORD_W-1:0] view_q, view_d;

    logic              step_ev, freeze_ev, dwell_wrap, trig_match;
    logic [BUS_W-1:0]  view_src;
    logic [WORD_W-1:0] trig_word;

    debug_monitor_word_mux #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) u_view_mux (
        .bus  (view_src),
        .sel  (index_q),
        .word (view_d)
    );

    debug_monitor_word_mux #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) u_trig_mux (
        .bus  (probe),
        .sel  (trig_index),
        .word (trig_word)
    );

    always_comb begin
        step_ev       = step & ~step_prev_q;
        freeze_ev     = freeze & ~freeze_prev_q;
        step_prev_d   = step;
        freeze_prev_d = freeze;
        dwell_wrap    = (dwell_q == CNT_W'(DWELL - 1));
        trig_match    = trig_en & ~frozen_q & (trig_word == trig_value);
        view_src      = frozen_q ? snap_q : probe;

        index_d = index_q;
        if (index_load) begin
            index_d = index_in;
        end else if (step_ev || (auto_mode && dwell_wrap)) begin
            index_d = index_q + IDX_W'(1);
        end

        dwell_d = dwell_q + CNT_W'(1);
        if (!auto_mode || index_load || step_ev || dwell_wrap) begin
            dwell_d = '0;
        end

        // A match outranks a coincident freeze press so the capture is tagged as a trigger
        snap_d     = snap_q;
        frozen_d   = frozen_q;
        trig_hit_d = trig_hit_q;
        if (trig_match) begin
            snap_d     = probe;
            frozen_d   = 1'b1;
            trig_hit_d = 1'b1;
        end else if (freeze_ev && !frozen_q) begin
            snap_d     = probe;
            frozen_d   = 1'b1;
        end else if (freeze_ev && frozen_q) begin
            frozen_d   = 1'b0;
            trig_hit_d = 1'b0;
        end

        switch_d = switch_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (sw_load && (sw_lane == LANE_W'(l))) begin
                switch_d[l*8 +: 8] = sw_byte;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_prev_q   <= 1'b0;
            freeze_prev_q <= 1'b0;
            index_q       <= '0;
            dwell_q       <= '0;
            frozen_q      <= 1'b0;
            trig_hit_q    <= 1'b0;
            snap_q        <= '0;
            switch_q      <= '0;
            view_q        <= '0;
        end else begin
            step_prev_q   <= step_prev_d;
            freeze_prev_q <= freeze_prev_d;
            index_q       <= index_d;
            dwell_q       <= dwell_d;
            frozen_q      <= frozen_d;
            trig_hit_q    <= trig_hit_d;
            snap_q        <= snap_d;
            switch_q      <= switch_d;
            view_q        <= view_d;
        end
    end

    assign view_word   = view_q;
    assign view_index  = index_q;
    assign switch_word = switch_q;
    assign switch_nz   = |switch_q;
    assign frozen      = frozen_q;
    assign trig_hit    = trig_hit_q;

endmodule
